// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus driver.
// Optional power-on init sequence is enabled with the LCD_INIT_EN macro.
package lcd_pkg;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned INIT_LEN    = 6;
  localparam int unsigned INIT_IDX_W  = 3;
  localparam int unsigned INIT_CYCLES = 300000;
  localparam int unsigned INIT_CNT_W  = 19;

  // Commands that need the long post-transfer wait
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Init command table, entry 0 in the least significant byte
  localparam logic [INIT_LEN*8-1:0] INIT_TABLE =
    {8'h01, 8'h06, 8'h0C, 8'h38, 8'h38, 8'h38};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
`ifdef LCD_INIT_EN
    , ST_INIT_WAIT
`endif
  } lcd_state_t;

  // One bus transfer: register select plus byte
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_req_t;

  // Clear and home commands take the long busy time on the panel
  function automatic logic is_long_cmd(input lcd_req_t req);
    return !req.rs && ((req.data == CMD_CLEAR) || (req.data == CMD_HOME));
  endfunction

  function automatic logic [7:0] init_cmd(input logic [INIT_IDX_W-1:0] idx);
    return INIT_TABLE[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lcd_req_capture.sv
// Request front end: wr/dr rising-edge detect, dr-over-wr priority,
// one-entry pending buffer and overrun pulse generation.
module lcd_req_capture
  import lcd_pkg::*;
(
  input  logic       clk_20m,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [7:0] dbi,
  input  logic       dr,
  input  logic [7:0] direc,
  input  logic       ready,
  output logic       head_valid_c,
  output lcd_req_t   head_c,
  output logic       pend_valid_nxt_c,
  output logic       overrun
);

  logic     wr_q;
  logic     dr_q;
  logic     pend_valid;
  lcd_req_t pend;

  logic     wr_rise;
  logic     dr_rise;
  logic     new_valid;
  logic     pend_load;
  logic     drop;
  lcd_req_t new_req;

  // Edge detect, head selection and pending-buffer bookkeeping
  always_comb begin
    wr_rise          = wr & ~wr_q;
    dr_rise          = dr & ~dr_q;
    new_valid        = wr_rise | dr_rise;
    new_req          = dr_rise ? lcd_req_t'({1'b0, direc}) : lcd_req_t'({1'b1, dbi});
    head_valid_c     = pend_valid | new_valid;
    head_c           = pend_valid ? pend : new_req;
    pend_load        = 1'b0;
    pend_valid_nxt_c = pend_valid;
    drop             = dr_rise & wr_rise;
    if (ready) begin
      // FSM takes the buffered entry first; a fresh request refills the slot
      if (pend_valid) begin
        pend_load        = new_valid;
        pend_valid_nxt_c = new_valid;
      end
    end else if (new_valid) begin
      if (pend_valid) begin
        drop = 1'b1;
      end else begin
        pend_load        = 1'b1;
        pend_valid_nxt_c = 1'b1;
      end
    end
  end

  // Edge registers, pending slot and overrun pulse
  always_ff @(posedge clk_20m or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= 1'b0;
      dr_q       <= 1'b0;
      pend_valid <= 1'b0;
      pend       <= '0;
      overrun    <= 1'b0;
    end else begin
      wr_q       <= wr;
      dr_q       <= dr;
      pend_valid <= pend_valid_nxt_c;
      overrun    <= drop;
      if (pend_load) begin
        pend <= new_req;
      end
    end
  end

endmodule

// File: rtl/lcd_bus_driver.sv
// LCD parallel bus driver: sequences RS/DB setup, E pulse, hold and the
// panel busy wait for each captured request.
// Define LCD_INIT_EN to add the 15 ms power-on wait and init command burst.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP      = 2,
  parameter int unsigned T_PULSE      = 12,
  parameter int unsigned T_HOLD       = 2,
  parameter int unsigned T_WAIT_SHORT = 800,
  parameter int unsigned T_WAIT_LONG  = 32800
) (
  input  logic       clk_20m,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [7:0] dbi,
  input  logic       dr,
  input  logic [7:0] direc,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       busy,
  output logic       overrun
);

  lcd_state_t       state;
  logic [CNT_W-1:0] cnt;

  logic     ready_c;
  logic     head_valid_c;
  lcd_req_t head_c;
  logic     pend_valid_nxt_c;
  logic     start_c;
  lcd_req_t start_req_c;
  logic     more_c;

`ifdef LCD_INIT_EN
  logic [INIT_CNT_W-1:0] init_cnt;
  logic [INIT_IDX_W-1:0] init_idx;
  logic                  init_done;
`endif

  assign lcd_rw = 1'b0;

  lcd_req_capture u_capture (
    .clk_20m          (clk_20m),
    .rst_n            (rst_n),
    .wr               (wr),
    .dbi              (dbi),
    .dr               (dr),
    .direc            (direc),
    .ready            (ready_c),
    .head_valid_c     (head_valid_c),
    .head_c           (head_c),
    .pend_valid_nxt_c (pend_valid_nxt_c),
    .overrun          (overrun)
  );

  // Select what IDLE launches next: init commands before host requests
  always_comb begin
    ready_c     = (state == ST_IDLE);
    start_c     = head_valid_c;
    start_req_c = head_c;
    more_c      = pend_valid_nxt_c;
`ifdef LCD_INIT_EN
    if (!init_done) begin
      ready_c     = 1'b0;
      start_c     = 1'b1;
      start_req_c = lcd_req_t'({1'b0, init_cmd(init_idx)});
      more_c      = 1'b1;
    end
`endif
  end

  // Transfer sequencer with registered bus outputs and busy flag
  always_ff @(posedge clk_20m or negedge rst_n) begin
    if (!rst_n) begin
`ifdef LCD_INIT_EN
      state     <= ST_INIT_WAIT;
      init_cnt  <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
`else
      state     <= ST_IDLE;
`endif
      cnt       <= '0;
      lcd_rs    <= 1'b0;
      lcd_db    <= 8'h00;
      lcd_e     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy <= start_c;
          if (start_c) begin
            lcd_rs <= start_req_c.rs;
            lcd_db <= start_req_c.data;
            cnt    <= CNT_W'(T_SETUP - 1);
            state  <= ST_SETUP;
`ifdef LCD_INIT_EN
            if (!init_done) begin
              init_idx  <= init_idx + INIT_IDX_W'(1);
              init_done <= (init_idx == INIT_IDX_W'(INIT_LEN - 1));
            end
`endif
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= CNT_W'(T_PULSE - 1);
            state <= ST_PULSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            cnt   <= CNT_W'(T_HOLD - 1);
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            cnt   <= is_long_cmd(lcd_req_t'({lcd_rs, lcd_db})) ?
                     CNT_W'(T_WAIT_LONG - 1) : CNT_W'(T_WAIT_SHORT - 1);
            state <= ST_WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            busy  <= more_c;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef LCD_INIT_EN
        ST_INIT_WAIT: begin
          busy <= 1'b1;
          if (init_cnt == INIT_CNT_W'(INIT_CYCLES - 1)) begin
            state <= ST_IDLE;
          end else begin
            init_cnt <= init_cnt + INIT_CNT_W'(1);
          end
        end
`endif
        default: begin
          lcd_e <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Self-checking bench for lcd_bus_driver (default build, LCD_INIT_EN undefined).
module tb_lcd_bus_driver;

  logic       clk_20m;
  logic       rst_n;
  logic       wr;
  logic [7:0] dbi;
  logic       dr;
  logic [7:0] direc;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       busy;
  logic       overrun;

  lcd_bus_driver dut (
    .clk_20m (clk_20m),
    .rst_n   (rst_n),
    .wr      (wr),
    .dbi     (dbi),
    .dr      (dr),
    .direc   (direc),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_e   (lcd_e),
    .lcd_db  (lcd_db),
    .busy    (busy),
    .overrun (overrun)
  );

  initial clk_20m = 1'b0;
  always #25 clk_20m = ~clk_20m;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // bus monitor state
  int       rise_t[$];
  bit [8:0] rise_v[$];
  bit [8:0] cur_v;
  bit       e_prev;
  int       e_high, ovr_cnt, busy_cnt, unstable;

  // reference model state for the random phase
  int       exp_t[$];
  bit [8:0] exp_v[$];
  int       free_at;
  bit       pend_v;
  bit [8:0] pend_d;
  int       exp_ovr;

  typedef struct {
    bit       is_cmd;
    bit [7:0] val;
    bit       exp_rs;
    bit [7:0] exp_db;
    int       exp_busy;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_20m);
    #1;
    cyc++;
    if (lcd_e && !e_prev) begin
      rise_t.push_back(cyc);
      rise_v.push_back({lcd_rs, lcd_db});
      cur_v = {lcd_rs, lcd_db};
    end
    if (lcd_e) begin
      e_high++;
      if ({lcd_rs, lcd_db} != cur_v) unstable++;
    end
    if (overrun) ovr_cnt++;
    if (busy) busy_cnt++;
    e_prev = lcd_e;
  endtask

  task automatic clear_mon();
    rise_t.delete();
    rise_v.delete();
    e_high = 0; ovr_cnt = 0; busy_cnt = 0; unstable = 0;
    e_prev = lcd_e;
  endtask

  task automatic pulse_req(input bit is_cmd, input bit [7:0] val);
    if (is_cmd) begin dr = 1'b1; direc = val; end
    else begin wr = 1'b1; dbi = val; end
    step();
    wr = 1'b0; dr = 1'b0;
    step();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin step(); n++; end while (busy && n < budget);
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_e(input int budget);
    int n = 0;
    while (!lcd_e && n < budget) begin step(); n++; end
    check("e_timeout", lcd_e, 1);
  endtask

  task automatic reset_dut();
    wr = 1'b0; dr = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    clear_mon();
  endtask

  // Transaction-level model: a request is served when the driver is free
  // and nothing is queued; otherwise it takes the single slot or is lost.
  task automatic model_start(input int c, input bit [8:0] v);
    bit long_w;
    long_w = (v[8] == 1'b0) && (v[7:0] == 8'h01 || v[7:0] == 8'h02);
    exp_t.push_back(c + 3);
    exp_v.push_back(v);
    free_at = c + 2 + 12 + 2 + (long_w ? 32800 : 800) + 1;
  endtask

  task automatic model_cycle(input int c, input bit wr_r, input bit dr_r,
                             input bit [7:0] d_data, input bit [7:0] c_data);
    bit dropped;
    bit [8:0] v;
    dropped = 1'b0;
    if (pend_v && c >= free_at) begin
      model_start(c, pend_d);
      pend_v = 1'b0;
    end
    if (wr_r && dr_r) begin
      dropped = 1'b1;
      wr_r = 1'b0;
    end
    if (wr_r || dr_r) begin
      v = dr_r ? {1'b0, c_data} : {1'b1, d_data};
      if (!pend_v && c >= free_at) model_start(c, v);
      else if (!pend_v) begin pend_v = 1'b1; pend_d = v; end
      else dropped = 1'b1;
    end
    if (dropped) exp_ovr++;
  endtask

  initial begin
    vec_t vecs[5];
    int k;
    bit wr_n, dr_n;

    vecs[0] = '{1'b1, 8'h87, 1'b0, 8'h87, 816};
    vecs[1] = '{1'b0, 8'h53, 1'b1, 8'h53, 816};
    vecs[2] = '{1'b1, 8'h01, 1'b0, 8'h01, 32816};
    vecs[3] = '{1'b0, 8'h01, 1'b1, 8'h01, 816};
    vecs[4] = '{1'b1, 8'h03, 1'b0, 8'h03, 816};

    rst_n = 1'b1; wr = 1'b0; dr = 1'b0; dbi = 8'h00; direc = 8'h00;
    #5 rst_n = 1'b0;
    step();
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_lcd_rw", lcd_rw, 0);
    check("rst_lcd_e", lcd_e, 0);
    check("rst_lcd_db", lcd_db, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    clear_mon();
    step();
    check("post_rst_busy", busy, 0);

    // single transfers from IDLE
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      k = cyc;
      pulse_req(vecs[i].is_cmd, vecs[i].val);
      wait_idle(40000);
      check($sformatf("vec%0d_rises", i), rise_t.size(), 1);
      if (rise_t.size() > 0) begin
        check($sformatf("vec%0d_e_delay", i), rise_t[0] - k, 3);
        check($sformatf("vec%0d_rs", i), rise_v[0][8], vecs[i].exp_rs);
        check($sformatf("vec%0d_db", i), rise_v[0][7:0], vecs[i].exp_db);
      end
      check($sformatf("vec%0d_e_width", i), e_high, 12);
      check($sformatf("vec%0d_busy_len", i), busy_cnt, vecs[i].exp_busy);
      check($sformatf("vec%0d_overrun", i), ovr_cnt, 0);
      check($sformatf("vec%0d_stable", i), unstable, 0);
      check($sformatf("vec%0d_rw", i), lcd_rw, 0);
    end

    // home command also takes the long wait; abort with reset afterwards
    clear_mon();
    pulse_req(1'b1, 8'h02);
    repeat (900) step();
    check("home_busy_long", busy, 1);
    check("home_rises", rise_t.size(), 1);
    reset_dut();

    // second write during PULSE is queued and follows one cycle after WAIT
    clear_mon();
    k = cyc;
    pulse_req(1'b0, 8'h53);
    wait_e(20);
    pulse_req(1'b0, 8'h61);
    wait_idle(3000);
    check("q_rises", rise_t.size(), 2);
    if (rise_t.size() > 1) begin
      check("q_first_db", rise_v[0][7:0], 8'h53);
      check("q_second_t", rise_t[1] - k, 820);
      check("q_second_rs", rise_v[1][8], 1);
      check("q_second_db", rise_v[1][7:0], 8'h61);
    end
    check("q_busy_len", busy_cnt, 1633);
    check("q_overrun", ovr_cnt, 0);

    // three requests while busy: third lost, second served
    clear_mon();
    k = cyc;
    pulse_req(1'b0, 8'h41);
    pulse_req(1'b1, 8'h0C);
    pulse_req(1'b0, 8'h42);
    wait_idle(3000);
    check("three_rises", rise_t.size(), 2);
    if (rise_t.size() > 1) begin
      check("three_second_t", rise_t[1] - k, 820);
      check("three_second_v", rise_v[1], {1'b0, 8'h0C});
    end
    check("three_overrun", ovr_cnt, 1);

    // dr and wr rise together: command wins, data lost
    clear_mon();
    dr = 1'b1; direc = 8'h80; wr = 1'b1; dbi = 8'h5A;
    step();
    dr = 1'b0; wr = 1'b0;
    wait_idle(3000);
    check("both_rises", rise_t.size(), 1);
    if (rise_t.size() > 0) check("both_v", rise_v[0], {1'b0, 8'h80});
    check("both_overrun", ovr_cnt, 1);
    check("both_busy_len", busy_cnt, 816);

    // reset during PULSE with a queued request
    clear_mon();
    pulse_req(1'b0, 8'h77);
    wait_e(20);
    pulse_req(1'b1, 8'h10);
    step();
    check("pre_rst_e", lcd_e, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_e", lcd_e, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_db", lcd_db, 0);
    check("async_rst_rs", lcd_rs, 0);
    step();
    step();
    rst_n = 1'b1;
    clear_mon();
    repeat (900) step();
    check("after_rst_rises", rise_t.size(), 0);
    check("after_rst_busy", busy_cnt, 0);

    // random request traffic against the transaction model
    reset_dut();
    exp_t.delete(); exp_v.delete();
    free_at = 0; pend_v = 1'b0; exp_ovr = 0;
    for (int n = 0; n < 20000; n++) begin
      step();
      wr_n = wr; dr_n = dr;
      if ($urandom_range(0, 199) == 0) begin
        wr_n = !wr;
        dbi  = 8'($urandom);
      end
      if ($urandom_range(0, 199) == 0) begin
        dr_n  = !dr;
        direc = 8'($urandom);
        if (direc == 8'h01 || direc == 8'h02) direc = 8'h80;
      end
      model_cycle(cyc, wr_n && !wr, dr_n && !dr, dbi, direc);
      wr = wr_n; dr = dr_n;
    end
    for (int n = 0; n < 5000; n++) begin
      step();
      model_cycle(cyc, 1'b0, 1'b0, dbi, direc);
      wr = 1'b0; dr = 1'b0;
      if (!pend_v && cyc > free_at + 4) break;
    end
    check("rand_count", rise_t.size(), exp_t.size());
    for (int i = 0; i < exp_t.size() && i < rise_t.size(); i++) begin
      check($sformatf("rand%0d_t", i), rise_t[i], exp_t[i]);
      check($sformatf("rand%0d_v", i), rise_v[i], exp_v[i]);
    end
    check("rand_overrun", ovr_cnt, exp_ovr);
    check("rand_e_width", e_high, 12 * exp_t.size());
    check("rand_stable", unstable, 0);
    check("rand_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
